// File: rtl/inst_encoder_loader.sv
// inst_encoder_loader
// Program loader that packs separated RV32I instruction fields back into 32-bit
// instruction words. It streams the words into instruction memory at consecutive
// word addresses through a one-entry output register, before the core is released.
module inst_encoder_loader #(
   parameter int                ADDR_W    = 10,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [6:0]        opcode,
   input  logic [4:0]        rd,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [2:0]        fn3,
   input  logic [6:0]        fn7,
   input  logic [31:0]       imm,
   output logic              mem_we,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   count,
   output logic              err
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACTIVE,
      ST_DRAIN,
      ST_DONE
   } state_t;

   state_t      state;
   state_t      next_state;
   logic [31:0] enc_word;
   logic        enc_ok;
   logic        accept;
   logic        wr_fire;

   // A new field set can enter whenever the output register is empty or is being emptied this cycle.
   assign in_ready = (state == ST_ACTIVE) & (~mem_we | mem_ready);
   assign accept   = in_valid & in_ready;
   assign wr_fire  = mem_we & mem_ready;
   assign busy     = (state != ST_IDLE);
   assign done     = (state == ST_DONE);

   // Re-pack the fields into the instruction format implied by the opcode; unknown opcodes are flagged.
   always_comb begin
      enc_word = 32'd0;
      enc_ok   = 1'b1;
      case (opcode)
         OP_LUI, OP_AUIPC: enc_word = {imm[31:12], rd, opcode};
         OP_JAL:           enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
         OP_JALR, OP_LOAD: enc_word = {imm[11:0], rs1, fn3, rd, opcode};
         OP_BRANCH:        enc_word = {imm[12], imm[10:5], rs2, rs1, fn3, imm[4:1], imm[11], opcode};
         OP_STORE:         enc_word = {imm[11:5], rs2, rs1, fn3, imm[4:0], opcode};
         OP_IMM: begin
            if ((fn3 == 3'b001) || (fn3 == 3'b101)) begin
               enc_word = {fn7, imm[4:0], rs1, fn3, rd, opcode};
            end else begin
               enc_word = {imm[11:0], rs1, fn3, rd, opcode};
            end
         end
         OP_REG:           enc_word = {fn7, rs2, rs1, fn3, rd, opcode};
         default:          enc_ok   = 1'b0;
      endcase
   end

   // Session state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Session sequencing: wait for start, take field sets until the last one, flush the held word, pulse done.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               next_state = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (accept && in_last) begin
               next_state = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!mem_we || mem_ready) begin
               next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Output register, write address, word count and sticky error; a write retiring and a new word loading can share a cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_we    <= 1'b0;
         mem_addr  <= BASE_ADDR;
         mem_wdata <= 32'd0;
         count     <= '0;
         err       <= 1'b0;
      end else if ((state == ST_IDLE) && start) begin
         mem_addr <= BASE_ADDR;
         count    <= '0;
         err      <= 1'b0;
      end else begin
         if (wr_fire) begin
            mem_addr <= mem_addr + ADDR_ONE;
            if (count != COUNT_MAX) begin
               count <= count + COUNT_ONE;
            end
         end
         if (accept && enc_ok) begin
            mem_we    <= 1'b1;
            mem_wdata <= enc_word;
         end else if (wr_fire) begin
            mem_we <= 1'b0;
         end
         if (accept && !enc_ok) begin
            err <= 1'b1;
         end
      end
   end

endmodule
